s1_rr_scheduler: RTL

//  Round-robin scheduler sharing one N-bit mux-and-register cell (4:1 select feeding an async-clear DFF)

---
 rtl/s1_sched_pkg.sv | 35 +++
 rtl/s1_mux_reg.sv | 40 ++++
 rtl/s1_rr_scheduler.sv | 114 +++++++++++
 3 files changed

// File: rtl/s1_sched_pkg.sv
// Shared types, widths and helpers for the round-robin scheduler slice.
package s1_sched_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } state_t;

    // First set request bit scanning from ptr upward, wrapping modulo NREQ.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [SEL_W-1:0] ptr,
                                                 input logic [NREQ-1:0]  req);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // One-hot vector for a requester index.
    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot = NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/s1_mux_reg.sv
// Shared N-bit cell: 4:1 select feeding a load-enabled register with async clear.
module s1_mux_reg
    import s1_sched_pkg::*;
#(
    parameter int unsigned N = 1
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [SEL_W-1:0] sel,
    input  logic             load_en,
    input  logic [N-1:0]     D00,
    input  logic [N-1:0]     D01,
    input  logic [N-1:0]     D10,
    input  logic [N-1:0]     D11,
    output logic [N-1:0]     q
);

    logic [N-1:0] mux_c;

    // Leg select; encoding equals the requester index.
    always_comb begin
        mux_c = D00;
        case (sel)
            2'd1:    mux_c = D01;
            2'd2:    mux_c = D10;
            2'd3:    mux_c = D11;
            default: mux_c = D00;
        endcase
    end

    // Register holds unless load_en; CLR clears it immediately.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            q <= '0;
        end else if (load_en) begin
            q <= mux_c;
        end
    end

endmodule

// File: rtl/s1_rr_scheduler.sv
// Round-robin scheduler granting four requesters access to one shared mux-and-register cell.
module s1_rr_scheduler
    import s1_sched_pkg::*;
#(
    parameter int unsigned N        = 1,
    parameter int unsigned PTR_INIT = 0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [NREQ-1:0]  req,
    input  logic [N-1:0]     D00,
    input  logic [N-1:0]     D01,
    input  logic [N-1:0]     D10,
    input  logic [N-1:0]     D11,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  ack,
    output logic             busy,
    output logic [N-1:0]     out,
    output logic             out_valid,
    output logic [SEL_W-1:0] out_src
);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] w;
    logic [SEL_W-1:0] idle_w;
    logic [SEL_W-1:0] b2b_w;
    logic [NREQ-1:0]  b2b_req;
    logic             load_en;

    // Capture happens only in LOAD; the mux follows the latched winner.
    assign load_en = (state == LOAD);

    // Fresh arbitration from IDLE, and back-to-back arbitration from DONE excluding the one just served.
    assign idle_w  = rr_pick(ptr, req);
    assign b2b_req = req & ~onehot(w);
    assign b2b_w   = rr_pick(w + SEL_W'(1), b2b_req);

    // Scheduler FSM, pointer and registered grant/ack/status outputs.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state     <= IDLE;
            ptr       <= SEL_W'(PTR_INIT);
            w         <= '0;
            gnt       <= '0;
            ack       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_src   <= '0;
        end else begin
            ack       <= '0;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        w     <= idle_w;
                        gnt   <= onehot(idle_w);
                        busy  <= 1'b1;
                        state <= SEL;
                    end
                end
                SEL: begin
                    if (!req[w]) begin
                        gnt   <= '0;
                        ptr   <= w + SEL_W'(1);
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    // ack/out_valid are registered here so they are high exactly while in DONE
                    out_src   <= w;
                    ack       <= onehot(w);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    ptr <= w + SEL_W'(1);
                    if (|b2b_req) begin
                        w     <= b2b_w;
                        gnt   <= onehot(b2b_w);
                        state <= SEL;
                    end else begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    s1_mux_reg #(
        .N (N)
    ) u_mux_reg (
        .CLK     (CLK),
        .CLR     (CLR),
        .sel     (w),
        .load_en (load_en),
        .D00     (D00),
        .D01     (D01),
        .D10     (D10),
        .D11     (D11),
        .q       (out)
    );

endmodule
